d_ff_test: RTL and testbench

D_FF_TEST -- requirements
Module: d_ff_test

---
 rtl/d_ff_test.sv | 72 +++++++
 tb/tb_d_ff_test.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/d_ff_test.sv
// Five WIDTH-bit registers capturing i_value, one per reset style:
// sync-only, async active-high, async active-low, mixed (async_n + sync), and none.
module d_ff_test #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             sync_reset,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value_sync_reset,
    output logic [WIDTH-1:0] o_value_async_reset,
    output logic [WIDTH-1:0] o_value_async_reset_n,
    output logic [WIDTH-1:0] o_value_mixed_reset,
    output logic [WIDTH-1:0] o_value_no_reset
);

    logic [WIDTH-1:0] sync_d,    sync_q;
    logic [WIDTH-1:0] async_d,   async_q;
    logic [WIDTH-1:0] async_n_d, async_n_q;
    logic [WIDTH-1:0] mixed_d,   mixed_q;
    logic [WIDTH-1:0] none_d,    none_q;

    // Synchronous resets are folded into next-state; async resets live in the flop sensitivity.
    always_comb begin
        sync_d    = sync_reset ? RST_VAL : i_value;
        async_d   = i_value;
        async_n_d = i_value;
        mixed_d   = sync_reset ? RST_VAL : i_value;
        none_d    = i_value;
    end

    always_ff @(posedge clk) begin
        sync_q <= sync_d;
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            async_q <= RST_VAL;
        end else begin
            async_q <= async_d;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            async_n_q <= RST_VAL;
        end else begin
            async_n_q <= async_n_d;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            mixed_q <= RST_VAL;
        end else begin
            mixed_q <= mixed_d;
        end
    end

    always_ff @(posedge clk) begin
        none_q <= none_d;
    end

    assign o_value_sync_reset    = sync_q;
    assign o_value_async_reset   = async_q;
    assign o_value_async_reset_n = async_n_q;
    assign o_value_mixed_reset   = mixed_q;
    assign o_value_no_reset      = none_q;

endmodule

// File: tb/tb_d_ff_test.sv
// Self-checking bench for d_ff_test: directed reset timeline, toggle run, then
// randomized inputs/resets against a per-register behavioural model.
`timescale 1ns/1ps
module tb_d_ff_test;

    localparam int unsigned W   = 8;
    localparam logic [W-1:0] RST = 8'h00;

    logic         clk;
    logic         async_reset_n;
    logic         sync_reset;
    logic         async_reset;
    logic [W-1:0] i_value;
    logic [W-1:0] o_sync, o_async, o_async_n, o_mixed, o_none;

    int checks   = 0;
    int failures = 0;

    // Expected register contents: 0 sync, 1 async, 2 async_n, 3 mixed, 4 none.
    logic [W-1:0] exp_q [5];

    d_ff_test #(.WIDTH(W), .RST_VAL(RST)) dut (
        .clk                   (clk),
        .async_reset_n         (async_reset_n),
        .sync_reset            (sync_reset),
        .async_reset           (async_reset),
        .i_value               (i_value),
        .o_value_sync_reset    (o_sync),
        .o_value_async_reset   (o_async),
        .o_value_async_reset_n (o_async_n),
        .o_value_mixed_reset   (o_mixed),
        .o_value_no_reset      (o_none)
    );

    // Clock idle low until 70 ns, then 100 MHz: first rising edge at 75 ns.
    initial begin
        clk = 1'b0;
        #70;
        forever #5 clk = ~clk;
    end

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_s, input logic [W-1:0] e_a,
                             input logic [W-1:0] e_an, input logic [W-1:0] e_m, input logic [W-1:0] e_n);
        check({tag, ".sync"},    o_sync,    e_s);
        check({tag, ".async"},   o_async,   e_a);
        check({tag, ".async_n"}, o_async_n, e_an);
        check({tag, ".mixed"},   o_mixed,   e_m);
        check({tag, ".none"},    o_none,    e_n);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_q[4]);
    endtask

    initial begin
        i_value       = 8'h01;
        sync_reset    = 1'b0;
        async_reset   = 1'b0;
        async_reset_n = 1'b1;

        // All resets pulsed with no clock: only the async registers react.
        wait_until(50);
        sync_reset = 1'b1; async_reset = 1'b1; async_reset_n = 1'b0;
        #1;
        check("noclk.async",   o_async,   RST);
        check("noclk.async_n", o_async_n, RST);
        check("noclk.mixed",   o_mixed,   RST);
        wait_until(60);
        sync_reset = 1'b0; async_reset = 1'b0; async_reset_n = 1'b1;
        #1;
        check("noclk_rel.async_n", o_async_n, RST);

        wait_until(76);
        check_all("first_edge", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);

        wait_until(80);
        sync_reset = 1'b1;
        wait_until(86);
        check_all("sync_rst", RST, 8'h01, 8'h01, RST, 8'h01);
        wait_until(90);
        sync_reset = 1'b0;
        wait_until(96);
        check_all("sync_rel", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);

        // async_reset_n mid-cycle while the clock runs.
        wait_until(100);
        i_value = 8'h5A;
        wait_until(102);
        async_reset_n = 1'b0;
        #1;
        check_all("arn_now", 8'h01, 8'h01, RST, RST, 8'h01);
        wait_until(106);
        check_all("arn_hold1", 8'h5A, 8'h5A, RST, RST, 8'h5A);
        wait_until(112);
        i_value = 8'h3C;
        wait_until(116);
        check_all("arn_hold2", 8'h3C, 8'h3C, RST, RST, 8'h3C);
        wait_until(118);
        async_reset_n = 1'b1;
        #1;
        check_all("arn_rel_mid", 8'h3C, 8'h3C, RST, RST, 8'h3C);
        wait_until(126);
        check_all("arn_rel_edge", 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);

        // Mixed priority: async_n released first, sync still holds mixed at reset.
        wait_until(128);
        async_reset_n = 1'b0; sync_reset = 1'b1;
        wait_until(132);
        async_reset_n = 1'b1;
        wait_until(136);
        check_all("mix_sync_hold", RST, 8'h3C, 8'h3C, RST, 8'h3C);
        wait_until(138);
        sync_reset = 1'b0;
        wait_until(141);
        check("mix_before_edge", o_mixed, RST);
        wait_until(146);
        check_all("mix_rel", 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);

        // async_reset independence; release just after an edge keeps RST until the next edge.
        wait_until(148);
        async_reset = 1'b1; i_value = 8'hC3;
        #1;
        check_all("ar_now", 8'h3C, RST, 8'h3C, 8'h3C, 8'h3C);
        wait_until(156);
        check_all("ar_hold", 8'hC3, RST, 8'hC3, 8'hC3, 8'hC3);
        wait_until(157);
        async_reset = 1'b0;
        wait_until(159);
        check("ar_rel_mid", o_async, RST);
        wait_until(166);
        check_all("ar_rel_edge", 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3);

        // Toggle data every cycle with no resets.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            i_value = ~i_value;
            @(posedge clk);
            #1;
            check_all("toggle", i_value, i_value, i_value, i_value, i_value);
        end

        // Randomized inputs and resets against the model.
        for (int m = 0; m < 5; m++) exp_q[m] = i_value;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            i_value       = W'($urandom);
            sync_reset    = ($urandom_range(0, 3) == 0);
            async_reset   = ($urandom_range(0, 3) == 0);
            async_reset_n = ($urandom_range(0, 3) != 0);
            #1;
            if (async_reset)    exp_q[1] = RST;
            if (!async_reset_n) begin
                exp_q[2] = RST;
                exp_q[3] = RST;
            end
            check_model("rand_mid");
            @(posedge clk);
            #1;
            exp_q[0] = sync_reset                    ? RST : i_value;
            exp_q[1] = async_reset                   ? RST : i_value;
            exp_q[2] = !async_reset_n                ? RST : i_value;
            exp_q[3] = (!async_reset_n || sync_reset) ? RST : i_value;
            exp_q[4] = i_value;
            check_model("rand_edge");
        end

        sync_reset = 1'b0; async_reset = 1'b0; async_reset_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
